// File: rtl/ppu_sprite_pixel_fsm.sv
// Sprite pixel generator: fetches pattern planes for two sprite slots per scanline,
// then emits a registered per-pixel colour/opacity/priority. Optional flip: SPRITE_FLIP_EN.
module ppu_sprite_pixel_fsm #(
  parameter int PT_STRIDE = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [8:0]   curr_row,
  input  logic [8:0]   curr_col,
  input  logic         pattern_sel,
  input  logic         sprite_0_on_tile,
  input  logic [7:0]   sprite_0_tile_num,
  input  logic [7:0]   sprite_0_row,
  input  logic [7:0]   sprite_0_col,
  input  logic [7:0]   sprite_0_attr,
  input  logic         sprite_0_is_0,
  input  logic         sprite_1_on_tile,
  input  logic [7:0]   sprite_1_tile_num,
  input  logic [7:0]   sprite_1_row,
  input  logic [7:0]   sprite_1_col,
  input  logic [7:0]   sprite_1_attr,
  input  logic         sprite_1_is_0,
  input  logic [127:0] sprite_colors,
  input  logic         fetch_start,
  output logic [15:0]  vram_read_addr,
  input  logic [7:0]   vram_read_data,
  output logic         fetch_busy,
  output logic         sprite_pixel_opaque,
  output logic [7:0]   sprite_pixel_color,
  output logic         sprite_pixel_behind,
  output logic         sprite_0_pixel
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] F0L  = 3'd1;
  localparam logic [2:0] F0H  = 3'd2;
  localparam logic [2:0] F1L  = 3'd3;
  localparam logic [2:0] F1H  = 3'd4;
  localparam logic [2:0] CAP  = 3'd5;

  logic [2:0] state;
  logic [7:0] lo0, hi0, lo1, hi1;
  logic       vflip0, vflip1, hflip0, hflip1;
  logic       unused_attr_bits;

`ifdef SPRITE_FLIP_EN
  assign vflip0 = sprite_0_attr[7];
  assign hflip0 = sprite_0_attr[6];
  assign vflip1 = sprite_1_attr[7];
  assign hflip1 = sprite_1_attr[6];
  assign unused_attr_bits = ^{sprite_0_attr[4:2], sprite_1_attr[4:2]};
`else
  assign vflip0 = 1'b0;
  assign hflip0 = 1'b0;
  assign vflip1 = 1'b0;
  assign hflip1 = 1'b0;
  assign unused_attr_bits = ^{sprite_0_attr[7:6], sprite_0_attr[4:2],
                              sprite_1_attr[7:6], sprite_1_attr[4:2]};
`endif

  function automatic logic [15:0] plane_addr(input logic psel, input logic [7:0] tile,
                                             input logic [7:0] row, input logic vflip,
                                             input logic [8:0] crow, input logic hi);
    logic [8:0] dy;
    logic [2:0] fy;
    dy = crow - {1'b0, row};
    fy = vflip ? 3'd7 - dy[2:0] : dy[2:0];
    return {3'b000, psel, 12'h000} + 16'(tile) * 16'(PT_STRIDE) + {13'd0, fy}
           + (hi ? 16'd8 : 16'd0);
  endfunction

  // Slots that are disabled or not on this scanline load transparent planes.
  function automatic logic [7:0] plane_gate(input logic on, input logic [7:0] row,
                                            input logic [8:0] crow, input logic [7:0] data);
    logic [8:0] dy;
    dy = crow - {1'b0, row};
    return (on && dy[8:3] == 6'd0) ? data : 8'h00;
  endfunction

  function automatic logic [1:0] slot_pix(input logic [7:0] lo, input logic [7:0] hi,
                                          input logic [7:0] col, input logic hflip,
                                          input logic [8:0] ccol);
    logic [8:0] dx;
    logic [2:0] idx;
    dx  = ccol - {1'b0, col};
    idx = hflip ? dx[2:0] : 3'd7 - dx[2:0];
    if (dx[8:3] != 6'd0) return 2'b00;
    return {hi[idx], lo[idx]};
  endfunction

  assign fetch_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      vram_read_addr <= 16'h0000;
      lo0            <= 8'h00;
      hi0            <= 8'h00;
      lo1            <= 8'h00;
      hi1            <= 8'h00;
    end else begin
      case (state)
        IDLE: if (fetch_start) begin
          state          <= F0L;
          vram_read_addr <= plane_addr(pattern_sel, sprite_0_tile_num, sprite_0_row,
                                       vflip0, curr_row, 1'b0);
        end
        F0L: begin
          state          <= F0H;
          vram_read_addr <= plane_addr(pattern_sel, sprite_0_tile_num, sprite_0_row,
                                       vflip0, curr_row, 1'b1);
        end
        F0H: begin
          state          <= F1L;
          vram_read_addr <= plane_addr(pattern_sel, sprite_1_tile_num, sprite_1_row,
                                       vflip1, curr_row, 1'b0);
          lo0            <= plane_gate(sprite_0_on_tile, sprite_0_row, curr_row, vram_read_data);
        end
        F1L: begin
          state          <= F1H;
          vram_read_addr <= plane_addr(pattern_sel, sprite_1_tile_num, sprite_1_row,
                                       vflip1, curr_row, 1'b1);
          hi0            <= plane_gate(sprite_0_on_tile, sprite_0_row, curr_row, vram_read_data);
        end
        F1H: begin
          state <= CAP;
          lo1   <= plane_gate(sprite_1_on_tile, sprite_1_row, curr_row, vram_read_data);
        end
        CAP: begin
          state <= IDLE;
          hi1   <= plane_gate(sprite_1_on_tile, sprite_1_row, curr_row, vram_read_data);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: per-slot pixel lookup and priority select.
  logic [1:0] pix0_p0, pix1_p0;
  logic       opaque_p0, behind_p0, s0_p0;
  logic [7:0] color_p0;

  always_comb begin
    pix0_p0   = slot_pix(lo0, hi0, sprite_0_col, hflip0, curr_col);
    pix1_p0   = slot_pix(lo1, hi1, sprite_1_col, hflip1, curr_col);
    opaque_p0 = 1'b0;
    behind_p0 = 1'b0;
    s0_p0     = 1'b0;
    color_p0  = 8'h00;
    if (pix0_p0 != 2'b00) begin
      opaque_p0 = 1'b1;
      behind_p0 = sprite_0_attr[5];
      s0_p0     = sprite_0_is_0;
      color_p0  = sprite_colors[8 * int'({sprite_0_attr[1:0], pix0_p0}) +: 8];
    end else if (pix1_p0 != 2'b00) begin
      opaque_p0 = 1'b1;
      behind_p0 = sprite_1_attr[5];
      s0_p0     = sprite_1_is_0;
      color_p0  = sprite_colors[8 * int'({sprite_1_attr[1:0], pix1_p0}) +: 8];
    end
  end

  // Stage p1: registered pixel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sprite_pixel_opaque <= 1'b0;
      sprite_pixel_color  <= 8'h00;
      sprite_pixel_behind <= 1'b0;
      sprite_0_pixel      <= 1'b0;
    end else begin
      sprite_pixel_opaque <= opaque_p0;
      sprite_pixel_color  <= color_p0;
      sprite_pixel_behind <= behind_p0;
      sprite_0_pixel      <= s0_p0;
    end
  end

endmodule
